// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard/redirect controls, instruction-memory port and IF/ID register outputs.
// The fetch stage connects as master; imem, hazard unit and decode connect as slave.
interface fetch_stage_if #(
    parameter int N = 64
);
    logic          stall;
    logic          redirect;
    logic [N-1:0]  redirect_target;
    logic [31:0]   IM_readData;
    logic [N-1:0]  IM_addr;
    logic [31:0]   IF_ID_instr;
    logic [N-1:0]  IF_ID_pc;
    logic          IF_ID_valid;
    logic [31:0]   fetch_count;

    modport master (
        input  stall, redirect, redirect_target, IM_readData,
        output IM_addr, IF_ID_instr, IF_ID_pc, IF_ID_valid, fetch_count
    );

    modport slave (
        output stall, redirect, redirect_target, IM_readData,
        input  IM_addr, IF_ID_instr, IF_ID_pc, IF_ID_valid, fetch_count
    );
endinterface

// File: rtl/fetch_stage.sv
// LEGv8 instruction-fetch stage: owns the PC, loads the IF/ID register and counts valid fetches.
// Each edge picks one mode by priority: reset, redirect (bubble), stall (hold), advance.
module fetch_stage #(
    parameter int           N        = 64,
    parameter logic [N-1:0] PC_RESET = '0
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master bus
);
    localparam logic [N-1:0] PC_STEP = N'(4);

    logic [N-1:0] pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [N-1:0] ifPc_q, ifPc_d;
    logic         valid_q, valid_d;
    logic [31:0]  count_q, count_d;

    // Redirect beats stall: whatever is stalled in IF/ID is on the wrong path.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        ifPc_d  = ifPc_q;
        valid_d = valid_q;
        count_d = count_q;
        if (bus.redirect) begin
            pc_d    = {bus.redirect_target[N-1:2], 2'b00};
            instr_d = 32'h0;
            ifPc_d  = '0;
            valid_d = 1'b0;
        end else if (!bus.stall) begin
            pc_d    = pc_q + PC_STEP;
            instr_d = bus.IM_readData;
            ifPc_d  = pc_q;
            valid_d = 1'b1;
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= PC_RESET;
            instr_q <= 32'h0;
            ifPc_q  <= '0;
            valid_q <= 1'b0;
            count_q <= 32'd0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ifPc_q  <= ifPc_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign bus.IM_addr     = pc_q;
    assign bus.IF_ID_instr = instr_q;
    assign bus.IF_ID_pc    = ifPc_q;
    assign bus.IF_ID_valid = valid_q;
    assign bus.fetch_count = count_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed test-plan steps followed by random control traffic,
// all compared against a cycle-level behavioural model of the fetch rules.
module tb_fetch_stage;
    localparam int N = 64;

    logic clk;
    logic reset;
    logic [31:0] imem [0:255];

    int checkCount;
    int passCount;
    int failCount;

    logic [63:0] expPc;
    logic [31:0] expInstr;
    logic [63:0] expIfPc;
    logic        expValid;
    logic [31:0] expCount;

    fetch_stage_if #(.N(N)) bus ();

    fetch_stage #(.N(N), .PC_RESET(64'h0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Instruction memory aliases every 1 KiB: only address bits [9:2] select the word.
    assign bus.IM_readData = imem[bus.IM_addr[9:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of controls, advance the model by the same rules, then settle past the edge.
    task automatic applyStimulus(input logic rst, input logic st, input logic rd, input logic [63:0] tgt);
        reset               = rst;
        bus.stall           = st;
        bus.redirect        = rd;
        bus.redirect_target = tgt;
        if (rst) begin
            expPc    = 64'h0;
            expInstr = 32'h0;
            expIfPc  = 64'h0;
            expValid = 1'b0;
            expCount = 32'd0;
        end else if (rd) begin
            expPc    = tgt & ~64'h3;
            expInstr = 32'h0;
            expIfPc  = 64'h0;
            expValid = 1'b0;
        end else if (!st) begin
            expInstr = imem[expPc[9:2]];
            expIfPc  = expPc;
            expValid = 1'b1;
            expPc    = expPc + 64'd4;
            expCount = expCount + 32'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag);
        checkValue({tag, ".IM_addr"},     bus.IM_addr,                expPc);
        checkValue({tag, ".IF_ID_instr"}, 64'(bus.IF_ID_instr),       64'(expInstr));
        checkValue({tag, ".IF_ID_pc"},    bus.IF_ID_pc,               expIfPc);
        checkValue({tag, ".IF_ID_valid"}, 64'(bus.IF_ID_valid),       64'(expValid));
        checkValue({tag, ".fetch_count"}, 64'(bus.fetch_count),       64'(expCount));
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        failCount  = 0;
        expPc = '0; expInstr = '0; expIfPc = '0; expValid = 1'b0; expCount = '0;
        for (int i = 0; i < 256; i++) imem[i] = $urandom() | 32'h1;

        $display("[TB] reset and free run");
        applyStimulus(1'b1, 1'b0, 1'b0, 64'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 64'h0);
        checkOutput("reset");
        checkValue("reset_addr", bus.IM_addr, 64'h0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);
            checkOutput("run");
        end
        checkValue("run_instr3", 64'(bus.IF_ID_instr), 64'(imem[3]));
        checkValue("run_pc3",    bus.IF_ID_pc,         64'hC);
        checkValue("run_count",  64'(bus.fetch_count), 64'd4);

        $display("[TB] stall after A1");
        applyStimulus(1'b1, 1'b0, 1'b0, 64'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 64'h0);
            checkOutput("stall");
        end
        checkValue("stall_addr",  bus.IM_addr,           64'h8);
        checkValue("stall_pc",    bus.IF_ID_pc,          64'h4);
        checkValue("stall_count", 64'(bus.fetch_count),  64'd2);
        applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);
        checkOutput("release");
        checkValue("release_instr", 64'(bus.IF_ID_instr), 64'(imem[2]));

        $display("[TB] redirect to 0x40");
        applyStimulus(1'b1, 1'b0, 1'b0, 64'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 64'h40);
        checkOutput("redir");
        checkValue("redir_valid", 64'(bus.IF_ID_valid), 64'd0);
        checkValue("redir_addr",  bus.IM_addr,          64'h40);
        checkValue("redir_count", 64'(bus.fetch_count), 64'd2);
        applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);
        checkOutput("redir_next");
        checkValue("redir_next_pc", bus.IF_ID_pc, 64'h40);

        $display("[TB] stall with redirect, misaligned target, wrap");
        applyStimulus(1'b0, 1'b1, 1'b1, 64'h80);
        checkOutput("stall_redir");
        checkValue("stall_redir_addr", bus.IM_addr, 64'h80);
        applyStimulus(1'b0, 1'b0, 1'b1, 64'h47);
        checkOutput("misalign");
        checkValue("misalign_addr", bus.IM_addr, 64'h44);
        applyStimulus(1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);
        checkOutput("wrap");
        checkValue("wrap_addr", bus.IM_addr, 64'h0);
        checkValue("wrap_pc",   bus.IF_ID_pc, 64'hFFFF_FFFF_FFFF_FFFC);

        $display("[TB] back-to-back redirects and mid-run reset");
        applyStimulus(1'b0, 1'b0, 1'b1, 64'h100);
        applyStimulus(1'b0, 1'b0, 1'b1, 64'h200);
        checkOutput("double_redir");
        checkValue("double_redir_addr", bus.IM_addr, 64'h200);
        applyStimulus(1'b0, 1'b1, 1'b0, 64'h0);
        applyStimulus(1'b1, 1'b1, 1'b1, 64'h300);
        checkOutput("mid_reset");
        checkValue("mid_reset_count", 64'(bus.fetch_count), 64'd0);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(49) == 0),
                          ($urandom_range(3) == 0),
                          ($urandom_range(7) == 0),
                          {$urandom(), $urandom()});
            checkOutput("random");
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined LEGv8 processor. It owns the program counter, drives the instruction-memory address, and registers the fetched instruction and its PC into the IF/ID pipeline register. It honours stalls from the hazard unit and redirects (taken branches) from later stages, inserting a bubble on redirect. It also keeps a retired-fetch counter for debug and dump.

## Interface
Parameters:
- N, 64, datapath and PC width
- PC_RESET, 0, PC value loaded on reset; must be word aligned

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- stall  in  1  hazard-unit stall; holds PC and IF/ID
- redirect  in  1  taken branch (PCSrc) from a later stage
- redirect_target  in  N  branch target address
- IM_readData  in  32  instruction word from imem; combinational read of IM_addr
- IM_addr  out  N  current PC, driven combinationally from the PC register
- IF_ID_instr  out  32  registered instruction
- IF_ID_pc  out  N  registered PC of IF_ID_instr
- IF_ID_valid  out  1  IF_ID contents are a real instruction, not a bubble
- fetch_count  out  32  number of instructions loaded valid into IF/ID

## Operation
- State: PC (N bits), IF_ID_instr, IF_ID_pc, IF_ID_valid, fetch_count. There is no other FSM; the stage mode is selected each cycle by priority.
- Priority per edge: reset > redirect > stall > advance.
- reset: PC <= PC_RESET; IF_ID_instr <= 32'h0; IF_ID_pc <= 0; IF_ID_valid <= 0; fetch_count <= 0.
- redirect: PC <= {redirect_target[N-1:2], 2'b00}; IF_ID_instr <= 0; IF_ID_valid <= 0; IF_ID_pc <= 0; fetch_count holds. Redirect overrides stall because the stalled instruction is on the wrong path.
- stall (no redirect): PC and all IF/ID fields hold; fetch_count holds.
- advance: PC <= PC + 4 (mod 2^N, wraps silently); IF_ID_instr <= IM_readData; IF_ID_pc <= PC; IF_ID_valid <= 1; fetch_count <= fetch_count + 1 (mod 2^32).
- Bubble encoding: instr 32'h0 decodes in the controller to all-zero control (no regWrite, memWrite, memRead or Branch). Downstream logic may also gate on IF_ID_valid.
- IM_addr = PC at all times. Only bits [9:2] index imem, so addresses alias every 1 KiB; this stage does not check range.
- Misaligned redirect_target: the low 2 bits are discarded and no error is flagged.

## Timing
- Fetch latency: 1 cycle. The word at IM_addr in cycle k appears on IF_ID_instr after edge k.
- After reset deasserts: cycle 0 has IM_addr = PC_RESET and IF_ID_valid = 0. After edge 0: IF_ID_instr = mem[PC_RESET], IF_ID_valid = 1, IM_addr = PC_RESET + 4.
- Redirect sampled at edge k: after edge k, IM_addr = target and IF/ID holds a bubble. After edge k+1, IF/ID holds mem[target]. Redirect costs exactly one bubble from this stage.
- Consecutive redirects are each honoured; the last one wins and the bubble persists.
- Stall held for n cycles freezes all outputs for n cycles. Advance resumes on the first edge with stall = 0.
- Reset asserted mid-stream (including during stall or redirect) clears all state at that edge.
- All outputs are glitch-free register outputs, except IM_addr, which is a direct copy of the PC register.

## Test plan
- Reset then free run with imem words A0..A3 at 0,4,8,12 → IF_ID_instr = A0, A1, A2, A3 on successive edges; IF_ID_pc = 0, 4, 8, 12; fetch_count = 1..4.
- stall high for 3 cycles after A1 is loaded → IF_ID stays A1 with pc 4, IM_addr stays 8, fetch_count stays 2; A2 loads on the first edge after release.
- redirect with target 0x40 at the edge after A1 → IF_ID_valid = 0, IF_ID_instr = 0, IM_addr = 0x40; next edge IF_ID_pc = 0x40, valid = 1; fetch_count unchanged during the bubble.
- stall and redirect together with target 0x80 → redirect wins: IM_addr = 0x80 and a bubble is inserted.
- redirect_target 0x47 → PC becomes 0x44.
- PC at 2^N−4 advances to 0 (wrap); reset asserted mid-run → PC = PC_RESET, valid = 0, fetch_count = 0 on that edge.
